ram_dp_ctrl: RTL and testbench

//  Initiator-side controller for the dual-port RAM (2 write/read ports, async read, write at posedge).
//  Two client request channels (valid/ready) drive the RAM ports; read data is registered into responses.

---
 rtl/ram_dp_ctrl_if.sv | 65 ++++++
 rtl/ram_dp_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ram_dp_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_ctrl_if.sv
// ----------------------------------------------------------------------------
// ram_dp_ctrl_if
// Purpose : bundles the two client request channels, the two read-response
//           channels and the two RAM port connections of ram_dp_ctrl.
// Signals (N = 1, 2):
//   reqN_valid_in / reqN_ready_out     request handshake
//   reqN_we_in, reqN_index_in,
//   reqN_data_in                       request payload (1 = write, 0 = read)
//   rspN_valid_out, rspN_data_out      read response (1-cycle pulse, held data)
//   ram_weN_out, ram_indexN_out,
//   ram_dataN_out                      drive to RAM port N
//   ram_dataN_in                       asynchronous read data from RAM port N
// Modports:
//   slave  : the controller side
//   master : the client / RAM-model side
// ----------------------------------------------------------------------------
interface ram_dp_ctrl_if #(
  parameter int DATAWIDTH = 64,
  parameter int LOGINDEX  = 8
);
  logic                 req1_valid_in;
  logic                 req1_ready_out;
  logic                 req1_we_in;
  logic [LOGINDEX-1:0]  req1_index_in;
  logic [DATAWIDTH-1:0] req1_data_in;
  logic                 req2_valid_in;
  logic                 req2_ready_out;
  logic                 req2_we_in;
  logic [LOGINDEX-1:0]  req2_index_in;
  logic [DATAWIDTH-1:0] req2_data_in;

  logic                 rsp1_valid_out;
  logic [DATAWIDTH-1:0] rsp1_data_out;
  logic                 rsp2_valid_out;
  logic [DATAWIDTH-1:0] rsp2_data_out;

  logic                 ram_we1_out;
  logic [LOGINDEX-1:0]  ram_index1_out;
  logic [DATAWIDTH-1:0] ram_data1_out;
  logic [DATAWIDTH-1:0] ram_data1_in;
  logic                 ram_we2_out;
  logic [LOGINDEX-1:0]  ram_index2_out;
  logic [DATAWIDTH-1:0] ram_data2_out;
  logic [DATAWIDTH-1:0] ram_data2_in;

  modport slave (
    input  req1_valid_in, req1_we_in, req1_index_in, req1_data_in,
    input  req2_valid_in, req2_we_in, req2_index_in, req2_data_in,
    output req1_ready_out, req2_ready_out,
    output rsp1_valid_out, rsp1_data_out, rsp2_valid_out, rsp2_data_out,
    output ram_we1_out, ram_index1_out, ram_data1_out,
    output ram_we2_out, ram_index2_out, ram_data2_out,
    input  ram_data1_in, ram_data2_in
  );

  modport master (
    output req1_valid_in, req1_we_in, req1_index_in, req1_data_in,
    output req2_valid_in, req2_we_in, req2_index_in, req2_data_in,
    input  req1_ready_out, req2_ready_out,
    input  rsp1_valid_out, rsp1_data_out, rsp2_valid_out, rsp2_data_out,
    input  ram_we1_out, ram_index1_out, ram_data1_out,
    input  ram_we2_out, ram_index2_out, ram_data2_out,
    output ram_data1_in, ram_data2_in
  );
endinterface

// File: rtl/ram_dp_ctrl.sv
// ----------------------------------------------------------------------------
// ram_dp_ctrl
// Purpose : initiator-side controller for a dual-port RAM (async read, write
//           at posedge). After reset or clear_in a sweep writes INITVALUE to
//           every entry, two entries per cycle; afterwards two client channels
//           drive the RAM ports and read data is registered into responses.
//           Same-index double writes are resolved in favour of port 2.
// Ports:
//   clock          in   posedge clock
//   reset          in   asynchronous active-high reset
//   clear_in       in   1-cycle pulse, re-runs the init sweep
//   init_done_out  out  1 once the sweep has completed (state RUN)
//   coll_count_out out  saturating count of write-write collisions
//   bus            ram_dp_ctrl_if.slave: requests, responses, RAM ports
// Options:
//   RAM_DP_CTRL_FWD_EN  when defined, a read that meets an accepted write to
//                       the same index on the other port returns the new data;
//                       otherwise it returns the pre-write RAM contents.
// ----------------------------------------------------------------------------
module ram_dp_ctrl #(
  parameter int                   DATAWIDTH = 64,
  parameter int                   INDEXSIZE = 256,
  parameter int                   LOGINDEX  = 8,
  parameter logic [DATAWIDTH-1:0] INITVALUE = {DATAWIDTH{1'b0}}
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_in,
  output logic        init_done_out,
  output logic [15:0] coll_count_out,
  ram_dp_ctrl_if.slave bus
);

  localparam logic [LOGINDEX-1:0] LAST_PTR = LOGINDEX'(INDEXSIZE - 2);
  localparam logic [LOGINDEX-1:0] PTR_STEP = LOGINDEX'(2);
  localparam logic [LOGINDEX-1:0] PTR_ONE  = LOGINDEX'(1);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [LOGINDEX-1:0]  ptr_r;

  logic                 ready_s;
  logic                 acc1_s;
  logic                 acc2_s;
  logic                 rd1_s;
  logic                 rd2_s;
  logic                 coll_s;

  logic                 ram_we1_s;
  logic                 ram_we2_s;
  logic [LOGINDEX-1:0]  ram_index1_s;
  logic [LOGINDEX-1:0]  ram_index2_s;
  logic [DATAWIDTH-1:0] ram_data1_s;
  logic [DATAWIDTH-1:0] ram_data2_s;

  logic [DATAWIDTH-1:0] rd_data1_s;
  logic [DATAWIDTH-1:0] rd_data2_s;

  logic                 rsp1_valid_r;
  logic                 rsp2_valid_r;
  logic [DATAWIDTH-1:0] rsp1_data_r;
  logic [DATAWIDTH-1:0] rsp2_data_r;
  logic [15:0]          coll_count_r;

  // Handshake: requests only flow in RUN and never in a clear cycle.
  assign ready_s = (state_r == RUN) & ~clear_in;
  assign acc1_s  = bus.req1_valid_in & ready_s;
  assign acc2_s  = bus.req2_valid_in & ready_s;
  assign rd1_s   = acc1_s & ~bus.req1_we_in;
  assign rd2_s   = acc2_s & ~bus.req2_we_in;
  assign coll_s  = acc1_s & bus.req1_we_in & acc2_s & bus.req2_we_in &
                   (bus.req1_index_in == bus.req2_index_in);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: leave INIT once the last pair is written, return on clear.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        if (clear_in) begin
          state_s = INIT;
        end else if (ptr_r == LAST_PTR) begin
          state_s = RUN;
        end else begin
          state_s = INIT;
        end
      end
      RUN: begin
        if (clear_in) begin
          state_s = INIT;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = INIT;
    endcase
  end

  // Sweep pointer: advances by a pair per INIT cycle, parked at 0 otherwise
  // so every new sweep (reset, clear in INIT or RUN) starts from entry 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= {LOGINDEX{1'b0}};
    end else if ((state_r == INIT) && !clear_in && (ptr_r != LAST_PTR)) begin
      ptr_r <= ptr_r + PTR_STEP;
    end else begin
      ptr_r <= {LOGINDEX{1'b0}};
    end
  end

  // RAM port drive: sweep pairs in INIT, client requests in RUN. On a
  // same-index double write port 1 is suppressed so port 2 wins.
  always_comb begin
    ram_we1_s    = 1'b0;
    ram_we2_s    = 1'b0;
    ram_index1_s = bus.req1_index_in;
    ram_index2_s = bus.req2_index_in;
    ram_data1_s  = bus.req1_data_in;
    ram_data2_s  = bus.req2_data_in;
    if (state_r == INIT) begin
      ram_we1_s    = ~clear_in;
      ram_we2_s    = ~clear_in;
      ram_index1_s = ptr_r;
      ram_index2_s = ptr_r + PTR_ONE;
      ram_data1_s  = INITVALUE;
      ram_data2_s  = INITVALUE;
    end else begin
      ram_we1_s    = acc1_s & bus.req1_we_in & ~coll_s;
      ram_we2_s    = acc2_s & bus.req2_we_in;
    end
  end

`ifdef RAM_DP_CTRL_FWD_EN
  // A read meeting the other port's accepted write to the same index sees the
  // new data. A reading port never writes, so no double-write case arises here.
  assign rd_data1_s = (ram_we2_s && (bus.req2_index_in == bus.req1_index_in)) ?
                      bus.req2_data_in : bus.ram_data1_in;
  assign rd_data2_s = (ram_we1_s && (bus.req1_index_in == bus.req2_index_in)) ?
                      bus.req1_data_in : bus.ram_data2_in;
`else
  // Async read sampled at the accept edge returns the pre-write contents.
  assign rd_data1_s = bus.ram_data1_in;
  assign rd_data2_s = bus.ram_data2_in;
`endif

  // Read responses: one-cycle valid pulse, data held until the next read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp1_valid_r <= 1'b0;
      rsp2_valid_r <= 1'b0;
      rsp1_data_r  <= {DATAWIDTH{1'b0}};
      rsp2_data_r  <= {DATAWIDTH{1'b0}};
    end else begin
      rsp1_valid_r <= rd1_s;
      rsp2_valid_r <= rd2_s;
      if (rd1_s) begin
        rsp1_data_r <= rd_data1_s;
      end else begin
        rsp1_data_r <= rsp1_data_r;
      end
      if (rd2_s) begin
        rsp2_data_r <= rd_data2_s;
      end else begin
        rsp2_data_r <= rsp2_data_r;
      end
    end
  end

  // Saturating write-write collision counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      coll_count_r <= 16'h0000;
    end else if (coll_s && (coll_count_r != 16'hFFFF)) begin
      coll_count_r <= coll_count_r + 16'h0001;
    end else begin
      coll_count_r <= coll_count_r;
    end
  end

  assign init_done_out      = (state_r == RUN);
  assign coll_count_out     = coll_count_r;
  assign bus.req1_ready_out = ready_s;
  assign bus.req2_ready_out = ready_s;
  assign bus.rsp1_valid_out = rsp1_valid_r;
  assign bus.rsp2_valid_out = rsp2_valid_r;
  assign bus.rsp1_data_out  = rsp1_data_r;
  assign bus.rsp2_data_out  = rsp2_data_r;
  assign bus.ram_we1_out    = ram_we1_s;
  assign bus.ram_we2_out    = ram_we2_s;
  assign bus.ram_index1_out = ram_index1_s;
  assign bus.ram_index2_out = ram_index2_s;
  assign bus.ram_data1_out  = ram_data1_s;
  assign bus.ram_data2_out  = ram_data2_s;

endmodule

// File: tb/tb_ram_dp_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_dp_ctrl
// Purpose : directed self-checking bench for ram_dp_ctrl with a behavioural
//           dual-port RAM (async read, posedge write, port 2 written last).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_dp_ctrl;

  logic        clock;
  logic        reset;
  logic        clear_in;
  logic        init_done_out;
  logic [15:0] coll_count_out;
  logic        scramble;
  int          checks;
  int          errors;

  logic [63:0] mem [256];

  ram_dp_ctrl_if #(.DATAWIDTH(64), .LOGINDEX(8)) bus ();

  ram_dp_ctrl #(
    .DATAWIDTH(64),
    .INDEXSIZE(256),
    .LOGINDEX (8),
    .INITVALUE(64'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clear_in      (clear_in),
    .init_done_out (init_done_out),
    .coll_count_out(coll_count_out),
    .bus           (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model; scramble fills non-zero junk so the sweep is observable.
  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < 256; i++) mem[i] <= {32'hA5A5_5A5A, 24'h0, 8'(i)} | 64'h1;
    end else begin
      if (bus.ram_we1_out) mem[bus.ram_index1_out] <= bus.ram_data1_out;
      if (bus.ram_we2_out) mem[bus.ram_index2_out] <= bus.ram_data2_out;
    end
  end

  assign bus.ram_data1_in = mem[bus.ram_index1_out];
  assign bus.ram_data2_in = mem[bus.ram_index2_out];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic req1(input logic v, input logic we, input logic [7:0] idx, input logic [63:0] d);
    bus.req1_valid_in = v; bus.req1_we_in = we; bus.req1_index_in = idx; bus.req1_data_in = d;
  endtask

  task automatic req2(input logic v, input logic we, input logic [7:0] idx, input logic [63:0] d);
    bus.req2_valid_in = v; bus.req2_we_in = we; bus.req2_index_in = idx; bus.req2_data_in = d;
  endtask

  // Counts clock edges until init_done_out rises; a full sweep is 128 edges.
  task automatic wait_sweep(input string tag);
    int cnt;
    cnt = 0;
    while (init_done_out !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    chk(tag, 64'(cnt), 64'd128);
  endtask

  // Reads every entry (two per cycle) and expects the sweep value 0.
  task automatic read_all(input string tag);
    for (int i = 0; i < 128; i++) begin
      req1(1'b1, 1'b0, 8'(2 * i), 64'h0);
      req2(1'b1, 1'b0, 8'(2 * i + 1), 64'h0);
      step();
      chk({tag, "_v1"}, 64'(bus.rsp1_valid_out), 64'd1);
      chk({tag, "_d1"}, bus.rsp1_data_out, 64'h0);
      chk({tag, "_v2"}, 64'(bus.rsp2_valid_out), 64'd1);
      chk({tag, "_d2"}, bus.rsp2_data_out, 64'h0);
    end
    req1(1'b0, 1'b0, 8'h00, 64'h0);
    req2(1'b0, 1'b0, 8'h00, 64'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_in = 1'b0;
    reset = 1'b1;
    scramble = 1'b1;
    req1(1'b0, 1'b0, 8'h00, 64'h0);
    req2(1'b0, 1'b0, 8'h00, 64'h0);
    step();
    scramble = 1'b0;
    step();

    // Reset values
    chk("rst_init_done", 64'(init_done_out), 64'd0);
    chk("rst_ready1", 64'(bus.req1_ready_out), 64'd0);
    chk("rst_ready2", 64'(bus.req2_ready_out), 64'd0);
    chk("rst_rsp1_valid", 64'(bus.rsp1_valid_out), 64'd0);
    chk("rst_rsp2_valid", 64'(bus.rsp2_valid_out), 64'd0);
    chk("rst_rsp1_data", bus.rsp1_data_out, 64'h0);
    chk("rst_coll", 64'(coll_count_out), 64'd0);

    // T1: sweep; a read held during INIT is accepted once RUN is reached
    reset = 1'b0;
    req1(1'b1, 1'b0, 8'd200, 64'h0);
    chk("t1_we1", 64'(bus.ram_we1_out), 64'd1);
    chk("t1_we2", 64'(bus.ram_we2_out), 64'd1);
    chk("t1_idx1", 64'(bus.ram_index1_out), 64'd0);
    chk("t1_idx2", 64'(bus.ram_index2_out), 64'd1);
    chk("t1_ready_init", 64'(bus.req1_ready_out), 64'd0);
    wait_sweep("t1_sweep_len");
    chk("t1_ready_run", 64'(bus.req1_ready_out), 64'd1);
    chk("t1_rsp_during_init", 64'(bus.rsp1_valid_out), 64'd0);
    step();
    chk("t1_held_rsp_valid", 64'(bus.rsp1_valid_out), 64'd1);
    chk("t1_held_rsp_data", bus.rsp1_data_out, 64'h0);
    req1(1'b0, 1'b0, 8'h00, 64'h0);
    read_all("t1_read");

    // T2: write then read on the other port, latency 1, data held
    req1(1'b1, 1'b1, 8'd5, 64'hDEAD);
    step();
    chk("t2_write_no_rsp", 64'(bus.rsp1_valid_out), 64'd0);
    req1(1'b0, 1'b0, 8'h00, 64'h0);
    req2(1'b1, 1'b0, 8'd5, 64'h0);
    step();
    chk("t2_rsp2_valid", 64'(bus.rsp2_valid_out), 64'd1);
    chk("t2_rsp2_data", bus.rsp2_data_out, 64'hDEAD);
    req2(1'b0, 1'b0, 8'h00, 64'h0);
    step();
    chk("t2_rsp2_pulse", 64'(bus.rsp2_valid_out), 64'd0);
    chk("t2_rsp2_hold", bus.rsp2_data_out, 64'hDEAD);

    // T3: double write to idx 9, port 2 wins
    req1(1'b1, 1'b1, 8'd9, 64'h1);
    req2(1'b1, 1'b1, 8'd9, 64'h2);
    #1;
    chk("t3_we1", 64'(bus.ram_we1_out), 64'd0);
    chk("t3_we2", 64'(bus.ram_we2_out), 64'd1);
    step();
    chk("t3_coll", 64'(coll_count_out), 64'd1);
    req1(1'b1, 1'b0, 8'd9, 64'h0);
    req2(1'b0, 1'b0, 8'h00, 64'h0);
    step();
    chk("t3_read9", bus.rsp1_data_out, 64'h2);

    // T4: cross-port read/write same index, both directions
    req1(1'b1, 1'b1, 8'd3, 64'h7);
    req2(1'b1, 1'b0, 8'd3, 64'h0);
    step();
`ifdef RAM_DP_CTRL_FWD_EN
    chk("t4_rd2_vs_wr1", bus.rsp2_data_out, 64'h7);
`else
    chk("t4_rd2_vs_wr1", bus.rsp2_data_out, 64'h0);
`endif
    req1(1'b1, 1'b0, 8'd4, 64'h0);
    req2(1'b1, 1'b1, 8'd4, 64'h44);
    step();
`ifdef RAM_DP_CTRL_FWD_EN
    chk("t4_rd1_vs_wr2", bus.rsp1_data_out, 64'h44);
`else
    chk("t4_rd1_vs_wr2", bus.rsp1_data_out, 64'h0);
`endif
    req1(1'b1, 1'b0, 8'd3, 64'h0);
    req2(1'b0, 1'b0, 8'h00, 64'h0);
    step();
    chk("t4_read3", bus.rsp1_data_out, 64'h7);
    chk("t4_coll_unchanged", 64'(coll_count_out), 64'd1);

    // T5: clear in RUN with an in-flight read response
    req1(1'b0, 1'b0, 8'h00, 64'h0);
    req2(1'b1, 1'b0, 8'd5, 64'h0);
    step();
    req1(1'b1, 1'b1, 8'd10, 64'h55);
    req2(1'b0, 1'b0, 8'h00, 64'h0);
    clear_in = 1'b1;
    #1;
    chk("t5_ready1", 64'(bus.req1_ready_out), 64'd0);
    chk("t5_ready2", 64'(bus.req2_ready_out), 64'd0);
    chk("t5_no_write", 64'(bus.ram_we1_out), 64'd0);
    chk("t5_inflight_valid", 64'(bus.rsp2_valid_out), 64'd1);
    chk("t5_inflight_data", bus.rsp2_data_out, 64'hDEAD);
    step();
    clear_in = 1'b0;
    req1(1'b0, 1'b0, 8'h00, 64'h0);
    chk("t5_init_done_low", 64'(init_done_out), 64'd0);
    chk("t5_rsp2_after", 64'(bus.rsp2_valid_out), 64'd0);
    // Clear again mid-sweep: no write that cycle, sweep restarts at 0
    for (int i = 0; i < 10; i++) step();
    chk("t5_mid_idx", 64'(bus.ram_index1_out), 64'd20);
    clear_in = 1'b1;
    #1;
    chk("t5_init_clear_we", 64'(bus.ram_we1_out), 64'd0);
    step();
    clear_in = 1'b0;
    chk("t5_restart_idx", 64'(bus.ram_index1_out), 64'd0);
    wait_sweep("t5_sweep_len");
    read_all("t5_read");

    // T6: reset mid-read, then mid-sweep
    req1(1'b1, 1'b1, 8'd20, 64'h1234);
    step();
    req1(1'b1, 1'b0, 8'd20, 64'h0);
    step();
    chk("t6_pre_valid", 64'(bus.rsp1_valid_out), 64'd1);
    chk("t6_pre_data", bus.rsp1_data_out, 64'h1234);
    reset = 1'b1;
    #1;
    chk("t6_rsp_dropped", 64'(bus.rsp1_valid_out), 64'd0);
    chk("t6_rsp_data_rst", bus.rsp1_data_out, 64'h0);
    chk("t6_init_done", 64'(init_done_out), 64'd0);
    chk("t6_ptr0_idx1", 64'(bus.ram_index1_out), 64'd0);
    chk("t6_ptr0_idx2", 64'(bus.ram_index2_out), 64'd1);
    chk("t6_ready", 64'(bus.req1_ready_out), 64'd0);
    #1;
    reset = 1'b0;
    req1(1'b0, 1'b0, 8'h00, 64'h0);
    for (int i = 0; i < 30; i++) step();
    chk("t6_mid_sweep_idx", 64'(bus.ram_index1_out), 64'd60);
    reset = 1'b1;
    #1;
    chk("t6_mid_sweep_rst", 64'(bus.ram_index1_out), 64'd0);
    chk("t6_coll_rst", 64'(coll_count_out), 64'd0);
    reset = 1'b0;
    wait_sweep("t6_sweep_len");
    req1(1'b1, 1'b0, 8'd20, 64'h0);
    step();
    chk("t6_read20", bus.rsp1_data_out, 64'h0);
    chk("t6_read20_valid", 64'(bus.rsp1_valid_out), 64'd1);
    req1(1'b0, 1'b0, 8'h00, 64'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
